// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM states, PPROT bit positions and the
// byte-strobe merge used by memory-backed slaves.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACCESS_WAIT = 2'd1,
    ACCESS_DONE = 2'd2
  } apb_state_e;

  localparam int PPROT_PRIV  = 0;
  localparam int PPROT_NSEC  = 1;
  localparam int PPROT_INSTR = 2;

  // Widest supported data path; narrower slaves zero-extend into these.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] wdata,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      if (strb[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB address decode: word index into the slave memory plus
// the error flag for below-base, out-of-range, misaligned or insecure writes.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'hA200_0000,
  parameter int                    SECURE_ONLY = 0
) (
  input  logic [ADDR_WIDTH-1:0]           paddr,
  input  logic [2:0]                      pprot,
  input  logic                            pwrite,
  output logic [idx_width(MEM_DEPTH)-1:0] idx,
  output logic                            err
);

  localparam int IDX_W      = idx_width(MEM_DEPTH);
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << BYTE_SHIFT) - 1);

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic                  below_base;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  prot_violation;
  logic                  unused_pprot;

  always_comb begin
    // The offset wraps when paddr is below the base, so underflow is judged
    // on the raw compare rather than on the offset.
    below_base     = paddr < BASE_ADDR;
    off            = paddr - BASE_ADDR;
    idx_full       = off >> BYTE_SHIFT;
    out_of_range   = idx_full >= ADDR_WIDTH'(MEM_DEPTH);
    misaligned     = |(off & ALIGN_MASK);
    prot_violation = (SECURE_ONLY != 0) && pwrite && pprot[PPROT_NSEC];
    err            = below_base || out_of_range || misaligned || prot_violation;
    idx            = idx_full[IDX_W-1:0];
  end

  assign unused_pprot = ^{pprot[PPROT_PRIV], pprot[PPROT_INSTR]};

endmodule

// File: rtl/apb_mem_slave_param.sv
// Parametrised APB4 scratch/config RAM slave with programmable wait states,
// byte-strobe writes and PSLVERR on bad address or protection.
module apb_mem_slave_param
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'hA200_0000,
  parameter int                    WAIT_STATES = 0,
  parameter int                    SECURE_ONLY = 0
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic                    pslverr,
  output logic [DATA_WIDTH-1:0]   prdata
);

  localparam int IDX_W = idx_width(MEM_DEPTH);

  apb_state_e            state_q,   state_d;
  logic [3:0]            cnt_q,     cnt_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic                  err_q,     err_d;
  logic                  wr_q,      wr_d;
  logic                  pready_q,  pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic [DATA_WIDTH-1:0] merged_word;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .BASE_ADDR  (BASE_ADDR),
    .SECURE_ONLY(SECURE_ONLY)
  ) u_decode (
    .paddr (paddr),
    .pprot (pprot),
    .pwrite(pwrite),
    .idx   (dec_idx),
    .err   (dec_err)
  );

  // NOTE: every variable gets a default before the case, so no path through
  // this block can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    wr_d    = wr_q;

    unique case (state_q)
      IDLE: begin
        // penable without a preceding SETUP is a protocol error and ignored.
        if (psel && !penable) begin
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = dec_idx;
          err_d   = dec_err;
          wr_d    = pwrite;
          state_d = (WAIT_STATES == 0) ? ACCESS_DONE : ACCESS_WAIT;
        end
      end
      ACCESS_WAIT: begin
        if (!psel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = ACCESS_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS_DONE: state_d = IDLE;
      default:     state_d = IDLE;
    endcase

    // Outputs are registered: they are loaded on the edge entering ACCESS_DONE.
    pready_d  = (state_d == ACCESS_DONE);
    pslverr_d = pready_d && err_d;
    prdata_d  = (pready_d && !err_d && !wr_d) ? mem_q[idx_d] : '0;
  end

  assign merged_word = DATA_WIDTH'(strb_merge(MAX_DATA_W'(mem_q[idx_q]),
                                              MAX_DATA_W'(pwdata),
                                              MAX_STRB_W'(pstrb)));

  always_comb begin
    mem_d = mem_q;
    if (state_q == ACCESS_DONE && pwrite && !err_q) mem_d[idx_q] = merged_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // NOTE: the array is reset because software relies on a zeroed scratch RAM;
  // this forces it into flops rather than a RAM macro.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave_param.sv
// Directed bench for apb_mem_slave_param: four instances cover zero/three/four
// wait states and the secure-only write filter on a shared APB bus.
module tb_apb_mem_slave_param;

  logic        clk;
  logic        n_rst;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [3:0]  pready;
  logic [3:0]  pslverr;
  logic [31:0] prdata [4];

  int n_asserts = 0;
  int n_fail    = 0;

  localparam int D_WS0 = 0;
  localparam int D_WS3 = 1;
  localparam int D_SEC = 2;
  localparam int D_WS4 = 3;

  apb_mem_slave_param #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .n_rst(n_rst), .paddr(paddr), .pprot(pprot), .psel(psel[D_WS0]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[D_WS0]), .pslverr(pslverr[D_WS0]), .prdata(prdata[D_WS0]));

  apb_mem_slave_param #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .n_rst(n_rst), .paddr(paddr), .pprot(pprot), .psel(psel[D_WS3]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[D_WS3]), .pslverr(pslverr[D_WS3]), .prdata(prdata[D_WS3]));

  apb_mem_slave_param #(.WAIT_STATES(1), .SECURE_ONLY(1)) u_sec (
    .clk(clk), .n_rst(n_rst), .paddr(paddr), .pprot(pprot), .psel(psel[D_SEC]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[D_SEC]), .pslverr(pslverr[D_SEC]), .prdata(prdata[D_SEC]));

  apb_mem_slave_param #(.WAIT_STATES(4)) u_ws4 (
    .clk(clk), .n_rst(n_rst), .paddr(paddr), .pprot(pprot), .psel(psel[D_WS4]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[D_WS4]), .pslverr(pslverr[D_WS4]), .prdata(prdata[D_WS4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer; n_acc counts ACCESS cycles up to and including pready.
  // bad_idle flags pslverr or prdata seen non-zero while pready was low.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [2:0] prot, output logic [31:0] rd,
                      output logic err, output int n_acc, output logic bad_idle);
    bad_idle = 1'b0;
    @(posedge clk); #1;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; pprot = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    n_acc = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pready[d]) break;
      if (pslverr[d] || prdata[d] != 32'h0) bad_idle = 1'b1;
      @(posedge clk); #1;
      n_acc++;
    end
    rd  = prdata[d];
    err = pslverr[d];
    @(posedge clk); #1;
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          n_acc;
  logic        bad;
  logic        seen_ready;

  initial begin
    n_rst = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (2) @(negedge clk);
    check("reset_pready", {28'h0, pready}, 32'h0);
    check("reset_pslverr", {28'h0, pslverr}, 32'h0);
    check("reset_prdata_ws0", prdata[D_WS0], 32'h0);
    n_rst = 1'b1;

    // Zero wait states: write then read back, both complete in the first ACCESS cycle.
    xfer(D_WS0, 1'b1, 32'hA200_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, rd, err, n_acc, bad);
    check("t1_wr_latency", n_acc, 1);
    check("t1_wr_err", {31'h0, err}, 32'h0);
    xfer(D_WS0, 1'b0, 32'hA200_0004, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t1_rd_latency", n_acc, 1);
    check("t1_rd_data", rd, 32'hDEAD_BEEF);
    check("t1_rd_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    check("t1_prdata_after", prdata[D_WS0], 32'h0);

    // Three wait states: first read after reset returns zero on the fourth ACCESS cycle.
    xfer(D_WS3, 1'b0, 32'hA200_0000, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t2_rd_latency", n_acc, 4);
    check("t2_rd_data", rd, 32'h0);
    check("t2_idle_clean", {31'h0, bad}, 32'h0);
    xfer(D_WS3, 1'b1, 32'hA200_003C, 32'h1234_5678, 4'hF, 3'b000, rd, err, n_acc, bad);
    check("t2_wr_last_err", {31'h0, err}, 32'h0);
    xfer(D_WS3, 1'b0, 32'hA200_003C, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t2_rd_last_word", rd, 32'h1234_5678);

    // Byte-strobe merge and an all-zero strobe.
    xfer(D_WS0, 1'b1, 32'hA200_0008, 32'h1122_3344, 4'hF, 3'b000, rd, err, n_acc, bad);
    xfer(D_WS0, 1'b1, 32'hA200_0008, 32'hAABB_CCDD, 4'b0101, 3'b000, rd, err, n_acc, bad);
    xfer(D_WS0, 1'b0, 32'hA200_0008, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t3_strb_merge", rd, 32'h11BB_33DD);
    xfer(D_WS0, 1'b1, 32'hA200_0008, 32'hFFFF_FFFF, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t3_strb0_err", {31'h0, err}, 32'h0);
    xfer(D_WS0, 1'b0, 32'hA200_0008, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t3_strb0_unchanged", rd, 32'h11BB_33DD);

    // Address errors: past the end, below the base, misaligned write.
    xfer(D_WS0, 1'b0, 32'hA200_0040, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t4_oor_err", {31'h0, err}, 32'h1);
    check("t4_oor_data", rd, 32'h0);
    xfer(D_WS0, 1'b0, 32'hA1FF_FFFC, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t4_below_err", {31'h0, err}, 32'h1);
    check("t4_below_data", rd, 32'h0);
    xfer(D_WS0, 1'b1, 32'hA200_0002, 32'h5555_5555, 4'hF, 3'b000, rd, err, n_acc, bad);
    check("t4_misalign_err", {31'h0, err}, 32'h1);
    check("t4_misalign_latency", n_acc, 1);
    xfer(D_WS0, 1'b0, 32'hA200_0000, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t4_word0_unchanged", rd, 32'h0);
    xfer(D_WS0, 1'b0, 32'hA200_003C, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t4_last_idx_ok", {31'h0, err}, 32'h0);

    // Secure-only instance: non-secure write rejected, secure write accepted.
    xfer(D_SEC, 1'b1, 32'hA200_0008, 32'hCAFE_F00D, 4'hF, 3'b010, rd, err, n_acc, bad);
    check("t5_nsec_err", {31'h0, err}, 32'h1);
    check("t5_nsec_latency", n_acc, 2);
    xfer(D_SEC, 1'b0, 32'hA200_0008, 32'h0, 4'h0, 3'b010, rd, err, n_acc, bad);
    check("t5_nsec_rd_err", {31'h0, err}, 32'h0);
    check("t5_word_still_zero", rd, 32'h0);
    xfer(D_SEC, 1'b1, 32'hA200_0008, 32'hCAFE_F00D, 4'hF, 3'b000, rd, err, n_acc, bad);
    check("t5_sec_wr_err", {31'h0, err}, 32'h0);
    xfer(D_SEC, 1'b0, 32'hA200_0008, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t5_sec_rd_data", rd, 32'hCAFE_F00D);

    // Four wait states: abort by dropping psel in the second ACCESS cycle.
    @(posedge clk); #1;
    psel[D_WS4] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hA200_0010;
    pwdata = 32'h0BAD_C0DE; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel[D_WS4] = 1'b0; penable = 1'b0;
    seen_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pready[D_WS4]) seen_ready = 1'b1;
    end
    check("t6_abort_no_ready", {31'h0, seen_ready}, 32'h0);
    xfer(D_WS4, 1'b0, 32'hA200_0010, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t6_abort_latency", n_acc, 5);
    check("t6_abort_no_write", rd, 32'h0);

    // Reset asserted in the middle of the wait phase of a write.
    @(posedge clk); #1;
    psel[D_WS4] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hA200_0010;
    pwdata = 32'h0BAD_C0DE; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("t6_rst_pready", {31'h0, pready[D_WS4]}, 32'h0);
    check("t6_rst_prdata", prdata[D_WS4], 32'h0);
    psel[D_WS4] = 1'b0; penable = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    xfer(D_WS4, 1'b0, 32'hA200_0010, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t6_post_rst_latency", n_acc, 5);
    check("t6_post_rst_no_write", rd, 32'h0);
    check("t6_post_rst_err", {31'h0, err}, 32'h0);
    xfer(D_WS0, 1'b0, 32'hA200_0004, 32'h0, 4'h0, 3'b000, rd, err, n_acc, bad);
    check("t6_mem_cleared", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
